sobel_window_gen: RTL and testbench

- Raster-order pixel front end for the edge detector.
- Accepts one 8-bit pixel per handshake and buffers the two previous image lines.
- Emits each fully-interior 3x3 neighbourhood as one packed window word, which the Sobel datapath consumes directly.
- Sits between the frame reader and edge_detection. It is the producer side of the edge detector's pixel interface.

---
 rtl/img_pkg.sv | 18 +
 rtl/sobel_line_buffer.sv | 27 ++
 rtl/sobel_window_gen.sv | 127 ++++++++++++
 tb/tb_sobel_window_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: pixel width, 3x3 window element
// indices and the packing function that maps (row, col) to a window slot.
package img_pkg;

  localparam int PIX_W = 8;

  // Row 0 is the oldest line, column 0 the leftmost pixel.
  typedef enum int {
    WIN_TL = 0, WIN_TC = 1, WIN_TR = 2,
    WIN_ML = 3, WIN_MC = 4, WIN_MR = 5,
    WIN_BL = 6, WIN_BC = 7, WIN_BR = 8
  } win_idx_e;

  function automatic int win_elem(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-read/one-write line store. The read returns the word held before this
// edge's write to the same address, so a column can be read and rotated in one cycle.
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  // NOTE: storage has no reset; a reset loop over every word would prevent
  // RAM inference, and row gating upstream keeps stale words from being used.
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 window stream for the Sobel datapath.
// Two line buffers plus a column shift register; one output register stage.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = img_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               pix_sof,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*PIX_W-1:0] win_data,
  output logic               win_last
);

  import img_pkg::*;

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(2);

  logic [CW-1:0]      col_q, col_d, col_cur;
  logic [RW-1:0]      row_q, row_d, row_cur;
  logic               win_valid_q, win_valid_d;
  logic               win_last_q, win_last_d;
  logic [9*PIX_W-1:0] win_data_q, win_data_d, win_shift;
  logic               accept, emit, frame_end;
  logic [2*PIX_W-1:0] lb_rdata, lb_wdata;
  logic [PIX_W-1:0]   lb0_rd, lb1_rd;

  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;

  // A start-of-frame pixel overrides the counters and is placed at (0,0).
  assign col_cur   = pix_sof ? '0 : col_q;
  assign row_cur   = pix_sof ? '0 : row_q;
  assign emit      = (row_cur >= ROW_FIRST_WIN) && (col_cur >= COL_FIRST_WIN);
  assign frame_end = (row_cur == ROW_LAST) && (col_cur == COL_LAST);

  // Upper half holds row-2, lower half row-1; each accept ages the column by one line.
  assign {lb1_rd, lb0_rd} = lb_rdata;
  assign lb_wdata         = {lb0_rd, pix_data};

  sobel_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (2 * PIX_W)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_cur),
    .wdata_i (lb_wdata),
    .rdata_o (lb_rdata)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      row_d = row_cur;
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
      end
    end
  end

  always_comb begin
    win_shift = win_data_q;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        win_shift[PIX_W*win_elem(r, c) +: PIX_W] = win_data_q[PIX_W*win_elem(r, c + 1) +: PIX_W];
      end
    end
    win_shift[PIX_W*win_elem(0, 2) +: PIX_W] = lb1_rd;
    win_shift[PIX_W*win_elem(1, 2) +: PIX_W] = lb0_rd;
    win_shift[PIX_W*win_elem(2, 2) +: PIX_W] = pix_data;
  end

  // Accept always advances the window; without an accept a taken window retires.
  always_comb begin
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    win_data_d  = win_data_q;
    if (accept) begin
      win_data_d  = win_shift;
      win_valid_d = emit;
      win_last_d  = emit && frame_end;
    end else if (win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_data_q  <= win_data_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
  assign win_data  = win_data_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on an 8x6 image, pixel = row*16+col.
module tb_sobel_window_gen;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int PW   = 8;
  localparam int WINW = 9 * PW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pix_valid = 1'b0;
  logic            pix_ready;
  logic [PW-1:0]   pix_data = '0;
  logic            pix_sof = 1'b0;
  logic            win_valid;
  logic            win_ready = 1'b1;
  logic [WINW-1:0] win_data;
  logic            win_last;

  sobel_window_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_last  (win_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WINW-1:0] data;
    logic            last;
    int              cyc;
  } win_rec_t;

  int       n_vec = 0;
  int       n_miss = 0;
  int       cyc = 0;
  int       first_valid_cyc = -1;
  int       acc_cyc [H][W];
  win_rec_t got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && win_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (!rst && win_valid && win_ready) got_q.push_back('{data: win_data, last: win_last, cyc: cyc});
  end

  task automatic check(input string tag, input logic [WINW-1:0] got, input logic [WINW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WINW-1:0] exp_win(input int r, input int c);
    logic [WINW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[PW*(3*i+j) +: PW] = 8'((r - 2 + i) * 16 + (c - 2 + j));
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    win_ready = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, WINW'(win_valid), WINW'(0));
    check({tag, "_data"}, win_data, '0);
    check({tag, "_last"}, WINW'(win_last), WINW'(0));
    check({tag, "_ready"}, WINW'(pix_ready), WINW'(1));
    @(posedge clk);
    #1;
  endtask

  // Sends raster pixels [start, start+n); sof on the first one when requested.
  task automatic send_pixels(input int start, input int n, input bit gap,
                             input logic [PW-1:0] xr, input bit sof_first);
    for (int k = 0; k < n; k++) begin
      int  idx, r, c;
      bit  done;
      idx       = start + k;
      r         = idx / W;
      c         = idx % W;
      pix_valid = 1'b1;
      pix_data  = 8'(r * 16 + c) ^ xr;
      pix_sof   = sof_first && (k == 0);
      done      = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
        @(negedge clk);
        if (pix_ready) begin
          acc_cyc[r][c] = cyc + 1;
          done = 1'b1;
        end
        @(posedge clk);
        #1;
      end
      check("pix_accept", WINW'(done), WINW'(1));
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      if (gap) idle(1);
    end
  endtask

  // Compares collected windows against the model for the first n_pix pixels of a frame.
  task automatic check_windows(input string tag, input int n_pix, input bit full, input bit timing);
    int k, expn;
    k    = 0;
    expn = 0;
    for (int idx = 0; idx < n_pix; idx++)
      if ((idx / W) >= 2 && (idx % W) >= 2) expn++;
    check({tag, "_count"}, WINW'(got_q.size()), WINW'(expn));
    for (int idx = 0; idx < n_pix; idx++) begin
      int r, c;
      r = idx / W;
      c = idx % W;
      if (r >= 2 && c >= 2) begin
        if (k < got_q.size()) begin
          check($sformatf("%s_data_r%0dc%0d", tag, r, c), got_q[k].data, exp_win(r, c));
          check($sformatf("%s_last_r%0dc%0d", tag, r, c), WINW'(got_q[k].last),
                WINW'(full && idx == W * H - 1));
          if (timing)
            check($sformatf("%s_cyc_r%0dc%0d", tag, r, c), WINW'(got_q[k].cyc), WINW'(acc_cyc[r][c]));
        end
        k++;
      end
    end
  endtask

  initial begin
    logic [WINW-1:0] w;
    int hits, wraps;

    // Reset state and full frame, continuous flow.
    do_reset();
    check_idle_outputs("reset");
    got_q.delete();
    first_valid_cyc = -1;
    send_pixels(0, W * H, 1'b0, 8'h00, 1'b1);
    idle(4);
    check("s1_latency", WINW'(first_valid_cyc), WINW'(acc_cyc[2][2]));
    check_windows("s1", W * H, 1'b1, 1'b1);
    if (got_q.size() == 24) begin
      w = got_q[0].data;
      check("s1_first_tl", WINW'(w[PW*0 +: PW]), WINW'(8'h00));
      check("s1_first_mc", WINW'(w[PW*4 +: PW]), WINW'(8'h11));
      check("s1_first_br", WINW'(w[PW*8 +: PW]), WINW'(8'h22));
      w = got_q[23].data;
      check("s1_last_mc", WINW'(w[PW*4 +: PW]), WINW'(8'h46));
      check("s1_last_flag", WINW'(got_q[23].last), WINW'(1));
    end

    // Row boundary: nothing follows col 0/1 accepts, no window wraps a line.
    for (int r = 2; r < H; r++) begin
      for (int c = 0; c < 2; c++) begin
        hits = 0;
        foreach (got_q[i]) if (got_q[i].cyc == acc_cyc[r][c]) hits++;
        check($sformatf("s2_no_win_r%0dc%0d", r, c), WINW'(hits), WINW'(0));
      end
    end
    wraps = 0;
    foreach (got_q[i]) begin
      bit has0, has7;
      has0 = 1'b0;
      has7 = 1'b0;
      w = got_q[i].data;
      for (int e = 0; e < 9; e++) begin
        if (w[PW*e +: 4] == 4'd0) has0 = 1'b1;
        if (w[PW*e +: 4] == 4'd7) has7 = 1'b1;
      end
      if (has0 && has7) wraps++;
    end
    check("s2_no_wrap", WINW'(wraps), WINW'(0));

    // Backpressure for 5 cycles after the first window.
    do_reset();
    got_q.delete();
    fork
      send_pixels(0, W * H, 1'b0, 8'h00, 1'b1);
      begin : bp
        int t;
        t = 0;
        do begin
          @(posedge clk);
          #2;
          t++;
        end while (!win_valid && t < 300);
        check("s3_first_valid", WINW'(win_valid), WINW'(1));
        win_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("s3_pix_ready", WINW'(pix_ready), WINW'(0));
          check("s3_hold_valid", WINW'(win_valid), WINW'(1));
          check("s3_hold_data", win_data, exp_win(2, 2));
          check("s3_hold_last", WINW'(win_last), WINW'(0));
          @(posedge clk);
          #2;
        end
        win_ready = 1'b1;
      end
    join
    idle(4);
    check_windows("s3", W * H, 1'b1, 1'b0);

    // Gapped input: valid toggles every cycle.
    do_reset();
    got_q.delete();
    first_valid_cyc = -1;
    send_pixels(0, W * H, 1'b1, 8'h00, 1'b1);
    idle(4);
    check("s4_latency", WINW'(first_valid_cyc), WINW'(acc_cyc[2][2]));
    check_windows("s4", W * H, 1'b1, 1'b1);

    // Mid-frame sof at (3,4): partial frame ends without win_last.
    do_reset();
    got_q.delete();
    send_pixels(0, 3 * W + 4, 1'b0, 8'h00, 1'b1);
    idle(3);
    check_windows("s5a", 3 * W + 4, 1'b0, 1'b1);
    got_q.delete();
    send_pixels(0, W * H, 1'b0, 8'h00, 1'b1);
    idle(4);
    check_windows("s5b", W * H, 1'b1, 1'b1);

    // Reset at row 4 of a frame with different content, then a clean frame.
    do_reset();
    send_pixels(0, 4 * W + 4, 1'b0, 8'h80, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_idle_outputs("s6_reset");
    got_q.delete();
    first_valid_cyc = -1;
    send_pixels(0, W * H, 1'b0, 8'h00, 1'b1);
    idle(4);
    check("s6_latency", WINW'(first_valid_cyc), WINW'(acc_cyc[2][2]));
    check_windows("s6", W * H, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
